// File: rtl/mem_lsu.sv
// Load/store unit between the multicycle datapath and a word-wide data memory.
// Handles byte/half/word accesses; sub-word stores are done as read-modify-write.
module mem_lsu #(
  parameter bit MISALIGN_ERR = 1'b1,
  parameter bit BIG_ENDIAN   = 1'b0
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic        i_req_we,
  input  logic [1:0]  i_req_size,
  input  logic        i_req_signed,
  input  logic [31:0] i_req_addr,
  input  logic [31:0] i_req_wdata,
  output logic        o_resp_valid,
  output logic [31:0] o_resp_rdata,
  output logic        o_resp_err,
  output logic        o_mem_we,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_wdata,
  input  logic [31:0] i_mem_rdata
);

  typedef enum logic [2:0] {IDLE, LOAD, RMW_RD, WRITE, RESP} state_t;

  state_t      r_state;
  state_t      w_next;
  logic [1:0]  r_size;
  logic        r_signed;
  logic [1:0]  r_lane;
  logic [31:0] r_wdata;
  logic [31:0] r_mem_addr;
  logic [31:0] r_mem_wdata;
  logic [31:0] r_resp_rdata;
  logic        r_resp_err;

  logic        w_byte;
  logic        w_half;
  logic        w_word;
  logic        w_misaligned;
  logic        w_err;
  logic [1:0]  w_off;
  logic [1:0]  w_lane;
  logic [4:0]  w_shift;
  logic [15:0] w_lo16;
  logic [31:0] w_load;
  logic [31:0] w_mask;
  logic [31:0] w_merged;

  assign w_byte       = (i_req_size == 2'b00);
  assign w_half       = (i_req_size == 2'b01);
  assign w_word       = i_req_size[1];
  assign w_misaligned = (w_half && i_req_addr[0]) || (w_word && (i_req_addr[1:0] != 2'b00));
  assign w_err        = MISALIGN_ERR && w_misaligned;

  // Lane is resolved at accept time so the later states only need a shift amount.
  always_comb begin
    w_off = i_req_addr[1:0];
    if (w_half) w_off[0] = 1'b0;
    if (w_word) w_off = 2'b00;
    w_lane = w_off;
    if (BIG_ENDIAN) begin
      if (w_byte)      w_lane = 2'd3 - w_off;
      else if (w_half) w_lane = 2'd2 - w_off;
      else             w_lane = 2'd0;
    end
  end

  assign w_shift = {r_lane, 3'b000};
  assign w_lo16  = 16'(i_mem_rdata >> w_shift);

  always_comb begin
    w_load = i_mem_rdata;
    case (r_size)
      2'b00:   w_load = {{24{r_signed & w_lo16[7]}}, w_lo16[7:0]};
      2'b01:   w_load = {{16{r_signed & w_lo16[15]}}, w_lo16};
      default: w_load = i_mem_rdata;
    endcase
  end

  assign w_mask   = ((r_size == 2'b00) ? 32'h0000_00FF : 32'h0000_FFFF) << w_shift;
  assign w_merged = (i_mem_rdata & ~w_mask) | ((r_wdata << w_shift) & w_mask);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) r_state <= IDLE;
    else          r_state <= w_next;
  end

  // Write enable is gated by reset so a reset during WRITE never reaches memory.
  always_comb begin
    w_next       = r_state;
    o_req_ready  = 1'b0;
    o_resp_valid = 1'b0;
    o_mem_we     = 1'b0;
    case (r_state)
      IDLE: begin
        o_req_ready = 1'b1;
        if (i_req_valid) begin
          if (w_err)          w_next = RESP;
          else if (!i_req_we) w_next = LOAD;
          else if (w_word)    w_next = WRITE;
          else                w_next = RMW_RD;
        end
      end
      LOAD:   w_next = RESP;
      RMW_RD: w_next = WRITE;
      WRITE: begin
        o_mem_we = i_rst_n;
        w_next   = RESP;
      end
      RESP: begin
        o_resp_valid = 1'b1;
        w_next       = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_size       <= 2'b00;
      r_signed     <= 1'b0;
      r_lane       <= 2'b00;
      r_wdata      <= 32'h0;
      r_mem_addr   <= 32'h0;
      r_mem_wdata  <= 32'h0;
      r_resp_rdata <= 32'h0;
      r_resp_err   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_req_valid) begin
            r_size   <= i_req_size;
            r_signed <= i_req_signed;
            r_lane   <= w_lane;
            r_wdata  <= i_req_wdata;
            if (w_err) begin
              r_resp_rdata <= 32'h0;
              r_resp_err   <= 1'b1;
            end else begin
              r_mem_addr <= {i_req_addr[31:2], 2'b00};
              if (i_req_we && w_word) r_mem_wdata <= i_req_wdata;
            end
          end
        end
        LOAD: begin
          r_resp_rdata <= w_load;
          r_resp_err   <= 1'b0;
        end
        RMW_RD: r_mem_wdata <= w_merged;
        WRITE: begin
          r_resp_rdata <= 32'h0;
          r_resp_err   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign o_mem_addr   = r_mem_addr;
  assign o_mem_wdata  = r_mem_wdata;
  assign o_resp_rdata = r_resp_rdata;
  assign o_resp_err   = r_resp_err;

endmodule

// File: tb/tb_mem_lsu.sv
// Bench for mem_lsu: three instances (default, alignment forced, big-endian),
// each with its own word memory model, driven from a table of directed vectors.
module tb_mem_lsu;

  logic        clk;
  logic        rstN;
  logic        memInit;
  logic        reqValid  [3];
  logic        reqReady  [3];
  logic        reqWe     [3];
  logic [1:0]  reqSize   [3];
  logic        reqSigned [3];
  logic [31:0] reqAddr   [3];
  logic [31:0] reqWdata  [3];
  logic        respValid [3];
  logic [31:0] respRdata [3];
  logic        respErr   [3];
  logic        memWe     [3];
  logic [31:0] memAddr   [3];
  logic [31:0] memWdata  [3];
  logic [31:0] memRdata  [3];

  logic [31:0] mem [3][64];
  int          writeCount [3];
  logic [31:0] lastWdata  [3];
  logic [31:0] lastWaddr  [3];

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          dut;
    logic        we;
    logic [1:0]  size;
    logic        sgn;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          lat;
    logic [31:0] rdata;
    logic        err;
    int          writes;
    logic [31:0] wword;
    logic [31:0] waddr;
  } vec_t;

  vec_t vecs [$];

  // Instance 0: default; 1: misaligned addresses forced aligned; 2: big-endian lanes.
  for (genvar g = 0; g < 3; g++) begin : gDut
    mem_lsu #(
      .MISALIGN_ERR(g != 1),
      .BIG_ENDIAN  (g == 2)
    ) dut (
      .i_clk       (clk),
      .i_rst_n     (rstN),
      .i_req_valid (reqValid[g]),
      .o_req_ready (reqReady[g]),
      .i_req_we    (reqWe[g]),
      .i_req_size  (reqSize[g]),
      .i_req_signed(reqSigned[g]),
      .i_req_addr  (reqAddr[g]),
      .i_req_wdata (reqWdata[g]),
      .o_resp_valid(respValid[g]),
      .o_resp_rdata(respRdata[g]),
      .o_resp_err  (respErr[g]),
      .o_mem_we    (memWe[g]),
      .o_mem_addr  (memAddr[g]),
      .o_mem_wdata (memWdata[g]),
      .i_mem_rdata (memRdata[g])
    );
    assign memRdata[g] = mem[g][memAddr[g][7:2]];
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: preload on memInit, otherwise write whole words and log every write.
  always @(posedge clk) begin
    for (int d = 0; d < 3; d++) begin
      if (memInit) begin
        for (int i = 0; i < 64; i++) mem[d][i] <= 32'h0;
        mem[d][4] <= 32'h8899_AABB;
      end else if (memWe[d]) begin
        mem[d][memAddr[d][7:2]] <= memWdata[d];
        writeCount[d] <= writeCount[d] + 1;
        lastWdata[d]  <= memWdata[d];
        lastWaddr[d]  <= memAddr[d];
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  function automatic vec_t mk(input int dut, input logic we, input logic [1:0] size,
                              input logic sgn, input logic [31:0] addr, input logic [31:0] wdata,
                              input int lat, input logic [31:0] rdata, input logic err,
                              input int writes, input logic [31:0] wword, input logic [31:0] waddr);
    vec_t v;
    v.dut = dut; v.we = we; v.size = size; v.sgn = sgn; v.addr = addr; v.wdata = wdata;
    v.lat = lat; v.rdata = rdata; v.err = err; v.writes = writes; v.wword = wword; v.waddr = waddr;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // Called just after a posedge with the target instance idle. Counts negedges
  // until resp_valid, so a load accepted at edge N responds on count 2.
  task automatic applyStimulus(input vec_t v, input string tag);
    int   d;
    int   lat;
    int   wc0;
    int   readyHigh;
    logic gotResp;
    d = v.dut;
    wc0 = writeCount[d];
    checkOutput({tag, " ready"}, {31'b0, reqReady[d]}, 32'd1);
    reqValid[d]  = 1'b1;
    reqWe[d]     = v.we;
    reqSize[d]   = v.size;
    reqSigned[d] = v.sgn;
    reqAddr[d]   = v.addr;
    reqWdata[d]  = v.wdata;
    @(posedge clk);
    #1;
    reqValid[d]  = 1'b0;
    reqWe[d]     = ~v.we;
    reqSize[d]   = ~v.size;
    reqSigned[d] = ~v.sgn;
    reqAddr[d]   = 32'hFFFF_FFFF;
    reqWdata[d]  = 32'h5A5A_5A5A;
    lat = 0;
    readyHigh = 0;
    gotResp = 1'b0;
    for (int k = 1; k <= 8 && !gotResp; k++) begin
      @(negedge clk);
      if (reqReady[d]) readyHigh++;
      if (respValid[d]) begin
        gotResp = 1'b1;
        lat = k;
      end
    end
    checkOutput({tag, " latency"}, 32'(lat), 32'(v.lat));
    checkOutput({tag, " rdata"}, respRdata[d], v.rdata);
    checkOutput({tag, " err"}, {31'b0, respErr[d]}, {31'b0, v.err});
    checkOutput({tag, " ready busy"}, 32'(readyHigh), 32'd0);
    checkOutput({tag, " writes"}, 32'(writeCount[d] - wc0), 32'(v.writes));
    if (v.writes != 0) begin
      checkOutput({tag, " wdata"}, lastWdata[d], v.wword);
      checkOutput({tag, " waddr"}, lastWaddr[d], v.waddr);
    end
    @(posedge clk);
    #1;
    checkOutput({tag, " pulse"}, {31'b0, respValid[d]}, 32'd0);
  endtask

  initial begin
    int          respSeen;
    int          readyLow;
    int          wc0;
    rstN    = 1'b0;
    memInit = 1'b1;
    for (int d = 0; d < 3; d++) begin
      reqValid[d] = 1'b0; reqWe[d] = 1'b0; reqSize[d] = 2'b00; reqSigned[d] = 1'b0;
      reqAddr[d] = 32'h0; reqWdata[d] = 32'h0;
    end

    // dut 0: MISALIGN_ERR=1, little-endian. Memory word 0x10 starts at 0x8899AABB.
    vecs.push_back(mk(0, 0, 2'b00, 1, 32'h13, 32'h0, 2, 32'hFFFF_FF88, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 2'b00, 0, 32'h13, 32'h0, 2, 32'h0000_0088, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 2'b01, 1, 32'h10, 32'h0, 2, 32'hFFFF_AABB, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 2'b01, 0, 32'h12, 32'h0, 2, 32'h0000_8899, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 2'b10, 0, 32'h10, 32'h0, 2, 32'h8899_AABB, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 2'b00, 0, 32'h11, 32'h0000_00CC, 3, 32'h0, 0, 1, 32'h8899_CCBB, 32'h10));
    vecs.push_back(mk(0, 0, 2'b10, 0, 32'h10, 32'h0, 2, 32'h8899_CCBB, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 2'b10, 0, 32'h14, 32'hDEAD_BEEF, 2, 32'h0, 0, 1, 32'hDEAD_BEEF, 32'h14));
    vecs.push_back(mk(0, 0, 2'b10, 0, 32'h14, 32'h0, 2, 32'hDEAD_BEEF, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 2'b01, 1, 32'h11, 32'h0, 1, 32'h0, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 2'b10, 0, 32'h12, 32'h0, 1, 32'h0, 1, 0, 0, 0));
    vecs.push_back(mk(0, 1, 2'b01, 0, 32'h12, 32'h0000_1234, 3, 32'h0, 0, 1, 32'h1234_CCBB, 32'h10));
    vecs.push_back(mk(0, 0, 2'b00, 0, 32'h12, 32'h0, 2, 32'h0000_0034, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 2'b01, 1, 32'h12, 32'h0, 2, 32'h0000_1234, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 2'b00, 1, 32'h10, 32'h0, 2, 32'hFFFF_FFBB, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 2'b00, 0, 32'h13, 32'hFFFF_FF7F, 3, 32'h0, 0, 1, 32'h7F34_CCBB, 32'h10));
    vecs.push_back(mk(0, 0, 2'b00, 1, 32'h13, 32'h0, 2, 32'h0000_007F, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 2'b11, 1, 32'h10, 32'h0, 2, 32'h7F34_CCBB, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 2'b01, 0, 32'h10, 32'h0, 2, 32'h0000_CCBB, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 2'b01, 0, 32'h16, 32'h0000_ABCD, 3, 32'h0, 0, 1, 32'hABCD_BEEF, 32'h14));
    vecs.push_back(mk(0, 0, 2'b01, 1, 32'h16, 32'h0, 2, 32'hFFFF_ABCD, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 2'b10, 0, 32'h14, 32'h0, 2, 32'hABCD_BEEF, 0, 0, 0, 0));
    // dut 1: MISALIGN_ERR=0, low address bits are dropped instead of faulting.
    vecs.push_back(mk(1, 0, 2'b01, 1, 32'h11, 32'h0, 2, 32'hFFFF_AABB, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 2'b10, 0, 32'h13, 32'h0, 2, 32'h8899_AABB, 0, 0, 0, 0));
    vecs.push_back(mk(1, 1, 2'b01, 0, 32'h13, 32'h0000_5566, 3, 32'h0, 0, 1, 32'h5566_AABB, 32'h10));
    vecs.push_back(mk(1, 0, 2'b10, 0, 32'h10, 32'h0, 2, 32'h5566_AABB, 0, 0, 0, 0));
    // dut 2: BIG_ENDIAN=1, byte 0x10 is the top byte of the word.
    vecs.push_back(mk(2, 0, 2'b00, 0, 32'h10, 32'h0, 2, 32'h0000_0088, 0, 0, 0, 0));
    vecs.push_back(mk(2, 0, 2'b00, 1, 32'h13, 32'h0, 2, 32'hFFFF_FFBB, 0, 0, 0, 0));
    vecs.push_back(mk(2, 0, 2'b01, 1, 32'h10, 32'h0, 2, 32'hFFFF_8899, 0, 0, 0, 0));
    vecs.push_back(mk(2, 0, 2'b01, 0, 32'h12, 32'h0, 2, 32'h0000_AABB, 0, 0, 0, 0));
    vecs.push_back(mk(2, 1, 2'b00, 0, 32'h11, 32'h0000_00CC, 3, 32'h0, 0, 1, 32'h88CC_AABB, 32'h10));
    vecs.push_back(mk(2, 0, 2'b10, 0, 32'h10, 32'h0, 2, 32'h88CC_AABB, 0, 0, 0, 0));
    vecs.push_back(mk(2, 0, 2'b01, 0, 32'h13, 32'h0, 1, 32'h0, 1, 0, 0, 0));

    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      checkOutput($sformatf("reset%0d resp_valid", d), {31'b0, respValid[d]}, 32'd0);
      checkOutput($sformatf("reset%0d rdata", d), respRdata[d], 32'h0);
      checkOutput($sformatf("reset%0d err", d), {31'b0, respErr[d]}, 32'd0);
      checkOutput($sformatf("reset%0d mem_we", d), {31'b0, memWe[d]}, 32'd0);
      checkOutput($sformatf("reset%0d mem_addr", d), memAddr[d], 32'h0);
      checkOutput($sformatf("reset%0d mem_wdata", d), memWdata[d], 32'h0);
    end
    rstN    = 1'b1;
    memInit = 1'b0;
    @(posedge clk);
    #1;

    foreach (vecs[i]) applyStimulus(vecs[i], $sformatf("row%0d", i));

    // Reset asserted during the WRITE cycle of a halfword store must drop it entirely.
    memInit = 1'b1;
    @(posedge clk);
    #1;
    memInit = 1'b0;
    wc0 = writeCount[0];
    reqValid[0] = 1'b1; reqWe[0] = 1'b1; reqSize[0] = 2'b01; reqSigned[0] = 1'b0;
    reqAddr[0] = 32'h12; reqWdata[0] = 32'h0000_1234;
    @(posedge clk);
    #1;
    reqValid[0] = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("rstwr mem_we before reset", {31'b0, memWe[0]}, 32'd1);
    rstN = 1'b0;
    #1;
    checkOutput("rstwr mem_we gated", {31'b0, memWe[0]}, 32'd0);
    @(posedge clk);
    #1;
    rstN = 1'b1;
    checkOutput("rstwr rdata cleared", respRdata[0], 32'h0);
    checkOutput("rstwr mem_addr cleared", memAddr[0], 32'h0);
    checkOutput("rstwr mem_wdata cleared", memWdata[0], 32'h0);
    respSeen = 0;
    readyLow = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (respValid[0]) respSeen++;
      if (!reqReady[0]) readyLow++;
    end
    checkOutput("rstwr no resp", 32'(respSeen), 32'd0);
    checkOutput("rstwr ready", 32'(readyLow), 32'd0);
    checkOutput("rstwr no write", 32'(writeCount[0] - wc0), 32'd0);
    checkOutput("rstwr word kept", mem[0][4], 32'h8899_AABB);
    @(posedge clk);
    #1;
    applyStimulus(mk(0, 0, 2'b10, 0, 32'h10, 32'h0, 2, 32'h8899_AABB, 0, 0, 0, 0), "postreset lw");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
